imm_rot_encoder: RTL

Iterative encoder that converts a 32-bit constant into the 12-bit rotated-immediate operand field {rot[3:0], imm8[7:0]}. This field is what the operand-2 shifter decodes in addressing mode 00 as ROR(zero-extended imm8, 2*rot). The block sits beside the instruction-generation / program-loader path and answers one request at a time over a start/ready/done handshake. It tests one rotation per clock and always returns the canonical encoding, which is the smallest rot that works.

---
 rtl/imm_rot_encoder_if.sv | 15 +
 rtl/imm_rot_encoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/imm_rot_encoder_if.sv
// imm_rot_encoder_if: request/result bundle for the rotated-immediate encoder.
// The requester drives start/value; the encoder returns ready/done and the
// {rot, imm8} result with its ok/inv qualifiers.
interface imm_rot_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        ready;
  logic        done;
  logic        ok;
  logic [11:0] imm12;
  logic        inv;

  modport master (output start, value, input ready, done, ok, imm12, inv);
  modport slave  (input start, value, output ready, done, ok, imm12, inv);
endinterface

// File: rtl/imm_rot_encoder.sv
// imm_rot_encoder: iterative search for the canonical rotated-immediate
// encoding {rot[3:0], imm8[7:0]} of a 32-bit constant, where the constant
// equals ROR(imm8, 2*rot). One rotation is tried per clock, smallest first,
// so the first hit is the canonical one.
// Optional feature macro: IMM_ROT_ENCODER_INVERT_EN -- when defined, a failed
// direct search is followed by a search of ~value, reported with inv=1.
module imm_rot_encoder (
  input  logic              clk,
  input  logic              reset,
  imm_rot_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Rotate left by twice the rotation count; {v, v} keeps wrapped bits.
  function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] r);
    logic [63:0] d;
    d = {v, v} << {r, 1'b0};
    return d[63:32];
  endfunction

  state_t      state_r, state_s;
  logic [31:0] val_r, val_s;
  logic [3:0]  rot_r, rot_s;
  logic        ok_r, ok_s;
  logic [11:0] imm12_r, imm12_s;
  logic        inv_r, inv_s;
  logic        ready_r, ready_s;
  logic        done_r, done_s;
  logic [31:0] rot_val_s;
`ifdef IMM_ROT_ENCODER_INVERT_EN
  logic        phase_r, phase_s;
`endif

  // State, operand and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      val_r   <= 32'h0000_0000;
      rot_r   <= 4'd0;
      ok_r    <= 1'b0;
      imm12_r <= 12'h000;
      inv_r   <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
`ifdef IMM_ROT_ENCODER_INVERT_EN
      phase_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      val_r   <= val_s;
      rot_r   <= rot_s;
      ok_r    <= ok_s;
      imm12_r <= imm12_s;
      inv_r   <= inv_s;
      ready_r <= ready_s;
      done_r  <= done_s;
`ifdef IMM_ROT_ENCODER_INVERT_EN
      phase_r <= phase_s;
`endif
    end
  end

  // Next-state logic: accept, test one rotation per cycle, publish result.
  always_comb begin
    state_s   = state_r;
    val_s     = val_r;
    rot_s     = rot_r;
    ok_s      = ok_r;
    imm12_s   = imm12_r;
    inv_s     = inv_r;
`ifdef IMM_ROT_ENCODER_INVERT_EN
    phase_s   = phase_r;
`endif
    rot_val_s = rol2(val_r, rot_r);

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          val_s   = bus.value;
          rot_s   = 4'd0;
`ifdef IMM_ROT_ENCODER_INVERT_EN
          phase_s = 1'b0;
`endif
          state_s = SEARCH;
        end else begin
          state_s = IDLE;
        end
      end
      SEARCH: begin
        if (rot_val_s[31:8] == 24'h00_0000) begin
          imm12_s = {rot_r, rot_val_s[7:0]};
          ok_s    = 1'b1;
`ifdef IMM_ROT_ENCODER_INVERT_EN
          inv_s   = phase_r;
`else
          inv_s   = 1'b0;
`endif
          state_s = DONE;
        end else if (rot_r != 4'd15) begin
          rot_s = rot_r + 4'd1;
        end else begin
`ifdef IMM_ROT_ENCODER_INVERT_EN
          // Direct pass exhausted: retry with the complemented constant.
          if (phase_r == 1'b0) begin
            val_s   = ~val_r;
            rot_s   = 4'd0;
            phase_s = 1'b1;
          end else begin
            ok_s    = 1'b0;
            imm12_s = 12'h000;
            inv_s   = 1'b0;
            state_s = DONE;
          end
`else
          ok_s    = 1'b0;
          imm12_s = 12'h000;
          inv_s   = 1'b0;
          state_s = DONE;
`endif
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Handshake flags are registered from the upcoming state.
    ready_s = (state_s == IDLE);
    done_s  = (state_s == DONE);
  end

  assign bus.ready = ready_r;
  assign bus.done  = done_r;
  assign bus.ok    = ok_r;
  assign bus.imm12 = imm12_r;
  assign bus.inv   = inv_r;

endmodule
